// File: rtl/adder_pipe.sv
// Pipelined carry-chain adder/subtractor. The operands are split into STAGES
// chunks of CHUNK bits. Each stage sums one chunk and registers the carry into
// the next stage. Operands travel alongside the op so that later stages can
// reach their chunks. A single global advance signal gives full backpressure.
module adder_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             oflow,
  output logic             zero
);

  localparam int unsigned CHUNK = WIDTH / STAGES;

  // Per-stage registered state
  logic             valid_q [STAGES];
  logic             carry_q [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] opa_q   [STAGES];
  logic [WIDTH-1:0] opb_q   [STAGES];
  logic             oflow_q;
  logic             zero_q;

  // Values entering each stage, i.e. the next state of that stage's registers
  logic             valid_d [STAGES];
  logic             cy_in   [STAGES];
  logic [WIDTH-1:0] low_in  [STAGES];
  logic [WIDTH-1:0] opa_d   [STAGES];
  logic [WIDTH-1:0] opb_d   [STAGES];
  logic [CHUNK:0]   part    [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic             carry_d [STAGES];
  logic             oflow_d;
  logic             zero_d;

  logic adv;

  assign adv       = out_ready | ~valid_q[STAGES-1];
  assign in_ready  = adv;
  assign out_valid = valid_q[STAGES-1];
  assign result    = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign oflow     = oflow_q;
  assign zero      = zero_q;

  // Stage inputs and per-chunk sums; subtraction is folded in at stage 0
  always_comb begin
    valid_d[0] = in_valid;
    opa_d[0]   = a;
    opb_d[0]   = sub ? ~b : b;
    low_in[0]  = '0;
    cy_in[0]   = sub ? 1'b1 : cin;
    for (int unsigned k = 1; k < STAGES; k++) begin
      valid_d[k] = valid_q[k-1];
      opa_d[k]   = opa_q[k-1];
      opb_d[k]   = opb_q[k-1];
      low_in[k]  = sum_q[k-1];
      cy_in[k]   = carry_q[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      part[k]    = {1'b0, opa_d[k][k*CHUNK +: CHUNK]}
                 + {1'b0, opb_d[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, cy_in[k]};
      sum_d[k]   = low_in[k];
      sum_d[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
      carry_d[k] = part[k][CHUNK];
    end
    zero_d  = (sum_d[STAGES-1] == '0);
    oflow_d = (opa_d[STAGES-1][WIDTH-1] == opb_d[STAGES-1][WIDTH-1]) &&
              (sum_d[STAGES-1][WIDTH-1] != opa_d[STAGES-1][WIDTH-1]);
  end

  // Pipeline registers: all stages move together on adv, hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        sum_q[k]   <= '0;
        opa_q[k]   <= '0;
        opb_q[k]   <= '0;
      end
      oflow_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        carry_q[k] <= carry_d[k];
        sum_q[k]   <= sum_d[k];
        opa_q[k]   <= opa_d[k];
        opb_q[k]   <= opb_d[k];
      end
      oflow_q <= oflow_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: directed arithmetic corners with latency checks,
// a stalled burst, reset with ops in flight, then random traffic scored
// against a plain-arithmetic reference.
module tb_adder_pipe;

  localparam int unsigned W = 32;
  localparam int unsigned S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         oflow;
  logic         zero;

  always #5 clk = ~clk;

  adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .cout(cout), .oflow(oflow),
    .zero(zero)
  );

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         o;
    logic         z;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   acc;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: whole-word arithmetic; overflow from the signed range
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    logic [W-1:0] be;
    logic [W:0]   f;
    longint       s;
    exp_t         e;
    be  = sb ? ~y : y;
    f   = {1'b0, x} + {1'b0, be} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
    s   = longint'($signed(x)) + longint'($signed(be)) + longint'(sb ? 1 : int'(ci));
    e.r = f[W-1:0];
    e.c = f[W];
    e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    e.z = (f[W-1:0] == '0);
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 9))
      0: return '0;
      1: return '1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h00FF_00FF;
      default: return $urandom();
    endcase
  endfunction

  // One clock: record handshakes mid-cycle, then step to just after the edge
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc) q.push_back(model(a, b, cin, sub));
    if (out_valid && out_ready) begin
      chk("pending_before_emit", W'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_result", result, e.r);
        chk("sb_cout", W'(cout), W'(e.c));
        chk("sb_oflow", W'(oflow), W'(e.o));
        chk("sb_zero", W'(zero), W'(e.z));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input logic sb);
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    cycle();
    chk("accepted", W'(acc), 1);
    in_valid = 1'b0;
  endtask

  task automatic send_expect(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic ci, input logic sb, input logic [W-1:0] er,
                             input logic ec, input logic eo, input logic ez);
    int n;
    send(x, y, ci, sb);
    n = 0;
    while (!out_valid && n < int'(S) + 4) begin
      cycle();
      n++;
    end
    chk({tag, "_latency"}, W'(n), W'(S - 1));
    chk({tag, "_result"}, result, er);
    chk({tag, "_cout"}, W'(cout), W'(ec));
    chk({tag, "_oflow"}, W'(oflow), W'(eo));
    chk({tag, "_zero"}, W'(zero), W'(ez));
  endtask

  initial begin
    logic [W-1:0] opa_arr[8];
    logic [W-1:0] opb_arr[8];
    logic [W-1:0] held;
    int idx, cyc, sent;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_result", result, 0);
    chk("rst_cout", W'(cout), 0);
    chk("rst_oflow", W'(oflow), 0);
    chk("rst_zero", W'(zero), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_in_ready", W'(in_ready), 1);

    // Directed arithmetic, each with a latency check
    send_expect("add_3_m1", 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd2, 1'b1, 1'b0, 1'b0);
    send_expect("sub_cin1", 32'd2, 32'd44, 1'b1, 1'b1, 32'hFFFF_FFD6, 1'b0, 1'b0, 1'b0);
    send_expect("sub_cin0", 32'd2, 32'd44, 1'b0, 1'b1, 32'hFFFF_FFD6, 1'b0, 1'b0, 1'b0);
    send_expect("pos_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    send_expect("wrap_zero", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    send_expect("chunk_carry", 32'h0000_00FF, 32'd1, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0);
    send_expect("cin_add", 32'h00FF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
    send_expect("sub_eq", 32'd5, 32'd5, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
    send_expect("neg_ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    repeat (2) cycle();

    // Burst of 8 with a 3-cycle consumer stall
    for (int i = 0; i < 8; i++) begin
      opa_arr[i] = pick();
      opb_arr[i] = pick();
    end
    idx = 0; cyc = 0; held = '0;
    in_valid = 1'b1;
    while (idx < 8 && cyc < 40) begin
      a = opa_arr[idx]; b = opb_arr[idx]; cin = idx[1]; sub = idx[0];
      out_ready = !(cyc >= 4 && cyc <= 6);
      #1;
      if (cyc == 4) begin
        chk("stall_out_valid", W'(out_valid), 1);
        held = result;
      end
      if (cyc >= 4 && cyc <= 6) chk("stall_in_ready", W'(in_ready), 0);
      if (cyc == 5 || cyc == 6) chk("stall_hold", result, held);
      cycle();
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("burst_cycles", W'(cyc), 11);
    repeat (S + 2) cycle();
    chk("burst_drained", W'(q.size()), 0);

    // Reset with three ops in flight
    in_valid = 1'b1;
    repeat (3) begin
      a = pick(); b = pick(); cin = 1'b0; sub = 1'b0;
      cycle();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", W'(out_valid), 0);
    chk("midrst_result", result, 0);
    chk("midrst_cout", W'(cout), 0);
    chk("midrst_oflow", W'(oflow), 0);
    chk("midrst_zero", W'(zero), 0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) begin
      cycle();
      chk("no_ghost", W'(out_valid), 0);
    end
    send_expect("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0,
                32'h2345_6789, 1'b0, 1'b0, 1'b0);
    repeat (2) cycle();

    // Random traffic with random backpressure and bubbles
    sent = 0; cyc = 0;
    while (sent < 2000 && cyc < 30000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = pick(); b = pick();
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      cycle();
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (S + 4) cycle();
    chk("random_count", W'(sent), 2000);
    chk("random_drained", W'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
